// File: rtl/reset_sequencer_pkg.sv
// Shared types, default counts and width helpers for the reset sequencer.
// No ports: imported by reset_sequencer and reset_req_arbiter.
package reset_sequencer_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_NUM_DOM   = 3;
  localparam int unsigned DEF_GRACE_CNT = 1023;
  localparam int unsigned DEF_HOLD_CNT  = 31;
  localparam int unsigned DEF_STAGE_GAP = 15;

  localparam int unsigned SRC_W   = 3;
  localparam int unsigned COUNT_W = 8;

  typedef enum logic [2:0] {
    ST_WAIT_LINK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_GRACE     = 3'd4
  } state_t;

  // Counter must hold the largest terminal count of any timed state.
  function automatic int unsigned cnt_width(input int unsigned grace,
                                            input int unsigned hold,
                                            input int unsigned gap);
    int unsigned m;
    m = grace;
    if (hold > m) m = hold;
    if (gap > m) m = gap;
    return $clog2(m + 1);
  endfunction

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_req_arbiter.sv
// Pending-request latch with fixed-priority (lowest index) grant and
// acknowledge generation for both direct grants and coalesced requests.
// Ports:
//   clock_i, reset_n_i : clock, async active-low reset
//   req_i              : raw request inputs, latched every cycle
//   grant_en           : arbitration allowed this cycle
//   coalesce_en        : clear and ack every pending request this cycle
//   grant_valid        : a requester is granted this cycle (combinational)
//   grant_idx          : index of the granted requester (combinational)
//   req_ack            : registered one-cycle acknowledge per requester
module reset_req_arbiter
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               grant_en,
  input  logic               coalesce_en,
  output logic               grant_valid,
  output logic [SRC_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] req_ack
);

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] onehot;
  logic [NUM_REQ-1:0] clr;

  // Lowest pending index; scanning downward lets the lowest hit win.
  always_comb begin
    grant_idx = '0;
    onehot    = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_idx = SRC_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
    grant_valid = grant_en & (|pending);
  end

  always_comb begin
    clr = '0;
    if (grant_valid) begin
      clr = onehot;
    end else if (coalesce_en) begin
      clr = pending;
    end
  end

  // A request arriving in the clearing cycle keeps its bit set.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending <= '0;
      req_ack <= '0;
    end else begin
      pending <= (pending & ~clr) | req_i;
      req_ack <= clr;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: arbitrates reset requests, waits a grace window,
// holds all domain resets, then releases domains one at a time in index
// order. Loss of MMCM lock or GBT link forces a full re-sequence.
// Ports:
//   clock_i, reset_n_i : 40 MHz fabric clock, async active-low reset
//   mmcms_locked_i     : all MMCMs locked
//   gbt_link_ok_i      : GBT link ready/valid
//   req_i              : reset requests (pulse or level)
//   req_ack_o          : one-cycle ack per serviced or coalesced requester
//   domain_reset_o     : active-high reset per domain
//   busy_o             : high whenever not in RUN
//   last_src_o         : last granted requester index
//   reset_count_o      : granted sequences, saturating at 255
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned NUM_DOM   = DEF_NUM_DOM,
  parameter int unsigned GRACE_CNT = DEF_GRACE_CNT,
  parameter int unsigned HOLD_CNT  = DEF_HOLD_CNT,
  parameter int unsigned STAGE_GAP = DEF_STAGE_GAP
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               mmcms_locked_i,
  input  logic               gbt_link_ok_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] req_ack_o,
  output logic [NUM_DOM-1:0] domain_reset_o,
  output logic               busy_o,
  output logic [SRC_W-1:0]   last_src_o,
  output logic [COUNT_W-1:0] reset_count_o
);

  localparam int unsigned CNT_W = cnt_width(GRACE_CNT, HOLD_CNT, STAGE_GAP);
  localparam int unsigned STG_W = idx_width(NUM_DOM);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(GRACE_CNT - 1);
  localparam logic [STG_W-1:0] LAST_DOM   = STG_W'(NUM_DOM - 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   counter, counter_d;
  logic [STG_W-1:0]   stage, stage_d, stage_inc;
  logic               release_en;
  logic [STG_W-1:0]   release_idx;

  logic               link_ok;
  logic               grant_en;
  logic               coalesce_en;
  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx;

  logic [NUM_DOM-1:0] domain_reset_d;
  logic               busy_d;
  logic [SRC_W-1:0]   last_src_d;
  logic [COUNT_W-1:0] reset_count_d;

  assign link_ok     = mmcms_locked_i & gbt_link_ok_i;
  assign grant_en    = link_ok & (state == ST_RUN);
  assign coalesce_en = link_ok & (state == ST_GRACE) & (counter == GRACE_LAST);
  assign stage_inc   = stage + STG_W'(1);

  reset_req_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .req_i       (req_i),
    .grant_en    (grant_en),
    .coalesce_en (coalesce_en),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .req_ack     (req_ack_o)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= ST_WAIT_LINK;
      counter        <= '0;
      stage          <= '0;
      domain_reset_o <= '1;
      busy_o         <= 1'b1;
      last_src_o     <= '0;
      reset_count_o  <= '0;
    end else begin
      state          <= state_d;
      counter        <= counter_d;
      stage          <= stage_d;
      domain_reset_o <= domain_reset_d;
      busy_o         <= busy_d;
      last_src_o     <= last_src_d;
      reset_count_o  <= reset_count_d;
    end
  end

  // Next-state, counter and release-event decode; link loss overrides all.
  always_comb begin
    state_d     = state;
    counter_d   = counter;
    stage_d     = stage;
    release_en  = 1'b0;
    release_idx = '0;
    if (!link_ok) begin
      state_d   = ST_WAIT_LINK;
      counter_d = '0;
    end else begin
      case (state)
        ST_WAIT_LINK: begin
          state_d   = ST_HOLD;
          counter_d = '0;
        end
        ST_HOLD: begin
          if (counter == HOLD_LAST) begin
            release_en  = 1'b1;
            release_idx = '0;
            counter_d   = '0;
            stage_d     = '0;
            state_d     = (NUM_DOM == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            counter_d = counter + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (counter == GAP_LAST) begin
            release_en  = 1'b1;
            release_idx = stage_inc;
            counter_d   = '0;
            stage_d     = stage_inc;
            if (stage_inc == LAST_DOM) state_d = ST_RUN;
          end else begin
            counter_d = counter + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (grant_valid) begin
            state_d   = ST_GRACE;
            counter_d = '0;
          end
        end
        ST_GRACE: begin
          if (counter == GRACE_LAST) begin
            state_d   = ST_HOLD;
            counter_d = '0;
          end else begin
            counter_d = counter + CNT_W'(1);
          end
        end
        default: begin
          state_d   = ST_WAIT_LINK;
          counter_d = '0;
        end
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    domain_reset_d = domain_reset_o;
    busy_d         = (state_d != ST_RUN);
    last_src_d     = last_src_o;
    reset_count_d  = reset_count_o;
    if (state_d == ST_WAIT_LINK || state_d == ST_HOLD) begin
      domain_reset_d = '1;
    end else if (release_en) begin
      for (int i = 0; i < int'(NUM_DOM); i++) begin
        if (release_idx == STG_W'(i)) domain_reset_d[i] = 1'b0;
      end
    end
    if (grant_valid) begin
      last_src_d = grant_idx;
      if (reset_count_o != '1) reset_count_d = reset_count_o + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer: a default-parameter
// instance for sequencing/arbitration/link loss, and a short-count instance
// for counter saturation and asynchronous reset.
module tb_reset_sequencer;

  localparam int HOLD  = 31;
  localparam int GAP   = 15;
  localparam int GRACE = 1023;

  logic       clk;
  logic       rst_n;
  logic       mmcm;
  logic       gbt;
  logic [3:0] req;
  logic [3:0] ack;
  logic [2:0] dom;
  logic       busy;
  logic [2:0] last;
  logic [7:0] cnt;

  logic       s_rst_n;
  logic [3:0] s_req;
  logic [3:0] s_ack;
  logic [2:0] s_dom;
  logic       s_busy;
  logic [2:0] s_last;
  logic [7:0] s_cnt;

  int checks;
  int errors;

  reset_sequencer #(
    .NUM_REQ(4), .NUM_DOM(3), .GRACE_CNT(1023), .HOLD_CNT(31), .STAGE_GAP(15)
  ) dut (
    .clock_i        (clk),
    .reset_n_i      (rst_n),
    .mmcms_locked_i (mmcm),
    .gbt_link_ok_i  (gbt),
    .req_i          (req),
    .req_ack_o      (ack),
    .domain_reset_o (dom),
    .busy_o         (busy),
    .last_src_o     (last),
    .reset_count_o  (cnt)
  );

  reset_sequencer #(
    .NUM_REQ(4), .NUM_DOM(3), .GRACE_CNT(2), .HOLD_CNT(1), .STAGE_GAP(1)
  ) sat (
    .clock_i        (clk),
    .reset_n_i      (s_rst_n),
    .mmcms_locked_i (1'b1),
    .gbt_link_ok_i  (1'b1),
    .req_i          (s_req),
    .req_ack_o      (s_ack),
    .domain_reset_o (s_dom),
    .busy_o         (s_busy),
    .last_src_o     (s_last),
    .reset_count_o  (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Entered just after the HOLD-entry edge; checks each domain release time.
  task automatic check_schedule(input string tag);
    logic [2:0] exp;
    exp = 3'b111;
    step(HOLD - 1);
    check_eq({tag, "_hold_end"}, 32'(dom), 32'(exp));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        step(GAP - 1);
        check_eq({tag, "_gap_end"}, 32'(dom), 32'(exp));
        check_eq({tag, "_busy_mid"}, 32'(busy), 32'd1);
      end
      step(1);
      exp[i] = 1'b0;
      check_eq({tag, "_release"}, 32'(dom), 32'(exp));
    end
    check_eq({tag, "_busy_run"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    s_rst_n = 1'b0;
    mmcm    = 1'b1;
    gbt     = 1'b0;
    req     = '0;
    s_req   = '0;
    step(3);
    check_eq("rst_dom", 32'(dom), 32'h7);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_last", 32'(last), 32'd0);
    check_eq("rst_cnt", 32'(cnt), 32'd0);
    rst_n   = 1'b1;
    s_rst_n = 1'b1;

    // Power-up: stays in WAIT_LINK until the link comes up.
    step(9);
    check_eq("wait_dom", 32'(dom), 32'h7);
    check_eq("wait_busy", 32'(busy), 32'd1);
    gbt = 1'b1;
    tick();
    check_eq("pu_hold_entry", 32'(dom), 32'h7);
    check_schedule("pu");
    check_eq("pu_cnt", 32'(cnt), 32'd0);

    // Single request on requester 2.
    req = 4'b0100;
    tick();
    check_eq("single_ack_early", 32'(ack), 32'd0);
    req = '0;
    tick();
    check_eq("single_ack", 32'(ack), 32'h4);
    check_eq("single_last", 32'(last), 32'd2);
    check_eq("single_cnt", 32'(cnt), 32'd1);
    check_eq("single_busy", 32'(busy), 32'd1);
    step(GRACE - 1);
    check_eq("single_grace_dom", 32'(dom), 32'h0);
    step(1);
    check_eq("single_hold_dom", 32'(dom), 32'h7);
    check_schedule("single");

    // Same-cycle requests 3 and 1: grant 1, coalesce 3 at HOLD entry.
    req = 4'b1010;
    tick();
    req = '0;
    tick();
    check_eq("prio_ack", 32'(ack), 32'h2);
    check_eq("prio_last", 32'(last), 32'd1);
    check_eq("prio_cnt", 32'(cnt), 32'd2);
    step(GRACE - 1);
    check_eq("prio_grace_ack", 32'(ack), 32'd0);
    step(1);
    check_eq("coal_ack", 32'(ack), 32'h8);
    check_eq("coal_cnt", 32'(cnt), 32'd2);
    check_eq("coal_last", 32'(last), 32'd1);
    check_eq("coal_dom", 32'(dom), 32'h7);
    check_schedule("coal");
    step(5);
    check_eq("coal_run_busy", 32'(busy), 32'd0);
    check_eq("coal_run_ack", 32'(ack), 32'd0);
    check_eq("coal_run_cnt", 32'(cnt), 32'd2);

    // Request 0 arriving during RELEASE waits for RUN.
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    check_eq("r3_ack", 32'(ack), 32'h8);
    check_eq("r3_cnt", 32'(cnt), 32'd3);
    step(GRACE);
    check_eq("r3_hold_dom", 32'(dom), 32'h7);
    check_eq("r3_hold_ack", 32'(ack), 32'd0);
    step(HOLD);
    check_eq("r3_dom0", 32'(dom), 32'h6);
    step(5);
    req = 4'b0001;
    tick();
    req = '0;
    check_eq("rel_no_ack0", 32'(ack), 32'd0);
    step(9);
    check_eq("rel_dom1", 32'(dom), 32'h4);
    check_eq("rel_no_ack1", 32'(ack), 32'd0);
    step(GAP);
    check_eq("rel_dom2", 32'(dom), 32'h0);
    check_eq("rel_busy", 32'(busy), 32'd0);
    check_eq("rel_no_ack2", 32'(ack), 32'd0);
    tick();
    check_eq("rel_ack", 32'(ack), 32'h1);
    check_eq("rel_last", 32'(last), 32'd0);
    check_eq("rel_cnt", 32'(cnt), 32'd4);
    check_eq("rel_busy_grant", 32'(busy), 32'd1);

    // Link loss mid-RELEASE with request 1 pending.
    step(GRACE);
    check_eq("ll_hold_dom", 32'(dom), 32'h7);
    step(HOLD);
    check_eq("ll_dom0", 32'(dom), 32'h6);
    req = 4'b0010;
    tick();
    req = '0;
    gbt = 1'b0;
    tick();
    check_eq("ll_dom", 32'(dom), 32'h7);
    check_eq("ll_busy", 32'(busy), 32'd1);
    check_eq("ll_ack", 32'(ack), 32'd0);
    step(5);
    check_eq("ll_wait_dom", 32'(dom), 32'h7);
    check_eq("ll_wait_ack", 32'(ack), 32'd0);
    gbt = 1'b1;
    tick();
    check_eq("ll_rehold_dom", 32'(dom), 32'h7);
    check_schedule("ll");
    check_eq("ll_run_ack", 32'(ack), 32'd0);
    tick();
    check_eq("ll_grant_ack", 32'(ack), 32'h2);
    check_eq("ll_grant_last", 32'(last), 32'd1);
    check_eq("ll_grant_cnt", 32'(cnt), 32'd5);

    // Saturation on the short-count instance.
    for (int i = 0; i < 260; i++) begin
      int n;
      n = 0;
      while (s_busy && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) check_eq("sat_timeout", 32'(s_busy), 32'd0);
      s_req = 4'b0001;
      tick();
      s_req = '0;
      tick();
      check_eq("sat_ack", 32'(s_ack), 32'h1);
      check_eq("sat_cnt", 32'(s_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end

    // Async reset in the middle of GRACE.
    step(10);
    s_req = 4'b0100;
    tick();
    s_req = '0;
    tick();
    check_eq("ar_pre_last", 32'(s_last), 32'd2);
    check_eq("ar_pre_dom", 32'(s_dom), 32'h0);
    #2;
    s_rst_n = 1'b0;
    #1;
    check_eq("ar_dom", 32'(s_dom), 32'h7);
    check_eq("ar_busy", 32'(s_busy), 32'd1);
    check_eq("ar_ack", 32'(s_ack), 32'd0);
    check_eq("ar_last", 32'(s_last), 32'd0);
    check_eq("ar_cnt", 32'(s_cnt), 32'd0);
    step(2);
    s_rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
